// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and limits for the two-port memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_AUX  = 1'b1
  } mem_owner_t;

  typedef struct packed {
    logic       valid;
    mem_owner_t owner;
  } mem_tag_t;

  localparam int MEM_ARB_MAX_RD_LATENCY = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arb_tag_pipe.sv
// ============================================================================
// Module   : mem_arb_tag_pipe
// Purpose  : DEPTH-stage shift register carrying read-return ownership tags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  mem_tag_t tag_in,
  output mem_tag_t tag_out
);

  localparam mem_tag_t c_tag_idle = '{valid: 1'b0, owner: OWNER_CORE};

  mem_tag_t r_stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= c_tag_idle;
    end else begin
      r_stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign tag_out = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one synchronous memory port between the core (port 0) and
//            an auxiliary master (port 1); steers read returns to their owner.
//            Define MEM_ARB_ROUND_ROBIN_EN for bounded-burst rotation,
//            otherwise port 0 has strict priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wr_data0,
  input  logic [31:0] wr_data1,
  input  logic        wr_ena0,
  input  logic        wr_ena1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] rd_data0,
  output logic [31:0] rd_data1,
  output logic        rd_valid0,
  output logic        rd_valid1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_ena,
  input  logic [31:0] mem_rd_data
);

  logic       w_win_core;
  logic       w_gnt0;
  logic       w_gnt1;
  mem_owner_t w_grant_owner;
  mem_tag_t   w_push_tag;
  mem_tag_t   w_pop_tag;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam int                 c_cnt_w     = $clog2(MAX_BURST + 1);
  localparam logic [c_cnt_w-1:0] c_burst_max = c_cnt_w'(MAX_BURST);

  mem_owner_t         r_last_owner;
  logic [c_cnt_w-1:0] r_burst_cnt;
  logic               w_keep;

  // A zero count means the previous cycle was idle: no streak to extend, so
  // contention goes to the port that did not own the last grant.
  always_comb begin
    w_keep     = (r_burst_cnt != '0) && (r_burst_cnt < c_burst_max);
    w_win_core = w_keep ? (r_last_owner == OWNER_CORE)
                        : (r_last_owner == OWNER_AUX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_owner <= OWNER_AUX;
      r_burst_cnt  <= '0;
    end else if (w_gnt0 || w_gnt1) begin
      r_last_owner <= w_grant_owner;
      if (w_grant_owner != r_last_owner) begin
        r_burst_cnt <= c_cnt_w'(1);
      end else if (r_burst_cnt != c_burst_max) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
    end else begin
      r_burst_cnt <= '0;
    end
  end
`else
  assign w_win_core = 1'b1;
`endif

  assign w_gnt0        = !rst && req0 && (!req1 || w_win_core);
  assign w_gnt1        = !rst && req1 && !(req0 && w_win_core);
  assign w_grant_owner = w_gnt1 ? OWNER_AUX : OWNER_CORE;
  assign gnt0          = w_gnt0;
  assign gnt1          = w_gnt1;

  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_ena  = 1'b0;
    if (w_gnt0) begin
      mem_addr    = addr0;
      mem_wr_data = wr_data0;
      mem_wr_ena  = wr_ena0;
    end else if (w_gnt1) begin
      mem_addr    = addr1;
      mem_wr_data = wr_data1;
      mem_wr_ena  = wr_ena1;
    end
  end

  always_comb begin
    w_push_tag.valid = (w_gnt0 && !wr_ena0) || (w_gnt1 && !wr_ena1);
    w_push_tag.owner = w_grant_owner;
  end

  mem_arb_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (w_push_tag),
    .tag_out (w_pop_tag)
  );

  // Data is broadcast to both ports; only the strobe identifies the owner.
  assign rd_data0  = mem_rd_data;
  assign rd_data1  = mem_rd_data;
  assign rd_valid0 = w_pop_tag.valid && (w_pop_tag.owner == OWNER_CORE);
  assign rd_valid1 = w_pop_tag.valid && (w_pop_tag.owner == OWNER_AUX);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed bench driving one latency-1 and one latency-2 arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [31:0] wr_data0 = '0, wr_data1 = '0;
  logic        wr_ena0 = 1'b0, wr_ena1 = 1'b0;
  logic [31:0] mem_rd_data = '0;

  logic        gnt0_l1, gnt1_l1, rd_valid0_l1, rd_valid1_l1, mem_wr_ena_l1;
  logic [31:0] rd_data0_l1, rd_data1_l1, mem_addr_l1, mem_wr_data_l1;
  logic        gnt0_l2, gnt1_l2, rd_valid0_l2, rd_valid1_l2, mem_wr_ena_l2;
  logic [31:0] rd_data0_l2, rd_data1_l2, mem_addr_l2, mem_wr_data_l2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RD_LATENCY(1), .MAX_BURST(4)) u_dut_l1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_ena0(wr_ena0), .wr_ena1(wr_ena1),
    .gnt0(gnt0_l1), .gnt1(gnt1_l1), .rd_data0(rd_data0_l1), .rd_data1(rd_data1_l1),
    .rd_valid0(rd_valid0_l1), .rd_valid1(rd_valid1_l1), .mem_addr(mem_addr_l1),
    .mem_wr_data(mem_wr_data_l1), .mem_wr_ena(mem_wr_ena_l1), .mem_rd_data(mem_rd_data)
  );

  mem_port_arbiter #(.RD_LATENCY(2), .MAX_BURST(4)) u_dut_l2 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_ena0(wr_ena0), .wr_ena1(wr_ena1),
    .gnt0(gnt0_l2), .gnt1(gnt1_l2), .rd_data0(rd_data0_l2), .rd_data1(rd_data1_l2),
    .rd_valid0(rd_valid0_l2), .rd_valid1(rd_valid1_l2), .mem_addr(mem_addr_l2),
    .mem_wr_data(mem_wr_data_l2), .mem_wr_ena(mem_wr_ena_l2), .mem_rd_data(mem_rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    logic exp_g0;

    // Reset: a pending write request must not reach the memory.
    req0 = 1'b1; wr_ena0 = 1'b1; addr0 = 32'h99;
    #2;
    chk("rst_gnt0", {31'd0, gnt0_l1}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1_l1}, 32'd0);
    chk("rst_wr_ena", {31'd0, mem_wr_ena_l1}, 32'd0);
    chk("rst_addr", mem_addr_l1, 32'd0);
    chk("rst_rdv0", {31'd0, rd_valid0_l2}, 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0; req0 = 1'b0; wr_ena0 = 1'b0;

    // Contention straight out of reset, both ports reading continuously.
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h100; addr1 = 32'h200;
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_g0 = ((i / 4) % 2) == 0;
`else
      exp_g0 = 1'b1;
`endif
      mid();
      chk($sformatf("cont_gnt0_%0d", i), {31'd0, gnt0_l1}, {31'd0, exp_g0});
      chk($sformatf("cont_gnt1_%0d", i), {31'd0, gnt1_l1}, {31'd0, !exp_g0});
      chk($sformatf("cont_both_%0d", i), {31'd0, gnt0_l2 & gnt1_l2}, 32'd0);
      chk($sformatf("cont_addr_%0d", i), mem_addr_l2, exp_g0 ? 32'h100 : 32'h200);
      next_cycle();
    end
    req0 = 1'b0; req1 = 1'b0;
    mid();
    chk("idle_addr", mem_addr_l1, 32'd0);
    next_cycle();
    next_cycle();
    next_cycle();

    // Port 1 write while port 0 idle.
    req1 = 1'b1; wr_ena1 = 1'b1; addr1 = 32'h20; wr_data1 = 32'h55;
    mid();
    chk("wr_gnt1", {31'd0, gnt1_l1}, 32'd1);
    chk("wr_gnt0", {31'd0, gnt0_l1}, 32'd0);
    chk("wr_ena", {31'd0, mem_wr_ena_l1}, 32'd1);
    chk("wr_addr", mem_addr_l1, 32'h20);
    chk("wr_data", mem_wr_data_l1, 32'h55);
    next_cycle();
    req1 = 1'b0; wr_ena1 = 1'b0;
    mid();
    chk("wr_norv1_l1", {31'd0, rd_valid1_l1}, 32'd0);
    chk("wr_norv0_l1", {31'd0, rd_valid0_l1}, 32'd0);
    next_cycle();
    mid();
    chk("wr_norv1_l2", {31'd0, rd_valid1_l2}, 32'd0);
    next_cycle();

    // Port 0 single read.
    req0 = 1'b1; addr0 = 32'h10;
    mid();
    chk("rd_gnt0", {31'd0, gnt0_l1}, 32'd1);
    chk("rd_addr", mem_addr_l1, 32'h10);
    chk("rd_wr_ena", {31'd0, mem_wr_ena_l1}, 32'd0);
    next_cycle();
    req0 = 1'b0; mem_rd_data = 32'hDEADBEEF;
    mid();
    chk("rd_rv0_l1", {31'd0, rd_valid0_l1}, 32'd1);
    chk("rd_data0_l1", rd_data0_l1, 32'hDEADBEEF);
    chk("rd_data1_l1", rd_data1_l1, 32'hDEADBEEF);
    chk("rd_rv1_l1", {31'd0, rd_valid1_l1}, 32'd0);
    chk("rd_rv0_l2_early", {31'd0, rd_valid0_l2}, 32'd0);
    next_cycle();
    mid();
    chk("rd_rv0_l1_once", {31'd0, rd_valid0_l1}, 32'd0);
    chk("rd_rv0_l2", {31'd0, rd_valid0_l2}, 32'd1);
    chk("rd_rv1_l2", {31'd0, rd_valid1_l2}, 32'd0);
    next_cycle();

    // Alternating-port reads on back-to-back cycles.
    req0 = 1'b1; addr0 = 32'h40;
    mid();
    chk("alt_gnt0", {31'd0, gnt0_l2}, 32'd1);
    next_cycle();
    req0 = 1'b0; req1 = 1'b1; addr1 = 32'h44;
    mid();
    chk("alt_gnt1", {31'd0, gnt1_l2}, 32'd1);
    chk("alt_rv0_l1", {31'd0, rd_valid0_l1}, 32'd1);
    chk("alt_rv0_l2_early", {31'd0, rd_valid0_l2}, 32'd0);
    next_cycle();
    req1 = 1'b0;
    mid();
    chk("alt_rv0_l2", {31'd0, rd_valid0_l2}, 32'd1);
    chk("alt_rv1_l2_early", {31'd0, rd_valid1_l2}, 32'd0);
    chk("alt_rv1_l1", {31'd0, rd_valid1_l1}, 32'd1);
    next_cycle();
    mid();
    chk("alt_rv1_l2", {31'd0, rd_valid1_l2}, 32'd1);
    chk("alt_rv0_l2_once", {31'd0, rd_valid0_l2}, 32'd0);
    chk("alt_rv1_l1_once", {31'd0, rd_valid1_l1}, 32'd0);
    next_cycle();

    // Reset while a read is outstanding discards it.
    req0 = 1'b1; addr0 = 32'h80;
    mid();
    chk("rr_gnt0", {31'd0, gnt0_l2}, 32'd1);
    next_cycle();
    req0 = 1'b0; rst = 1'b1;
    mid();
    chk("rr_rv0_l1", {31'd0, rd_valid0_l1}, 32'd0);
    chk("rr_rv0_l2_a", {31'd0, rd_valid0_l2}, 32'd0);
    next_cycle();
    rst = 1'b0;
    mid();
    chk("rr_rv0_l2_b", {31'd0, rd_valid0_l2}, 32'd0);
    chk("rr_rv1_l2_b", {31'd0, rd_valid1_l2}, 32'd0);
    next_cycle();
    req0 = 1'b1; req1 = 1'b1;
    mid();
    chk("rr_first_gnt0", {31'd0, gnt0_l2}, 32'd1);
    chk("rr_first_gnt1", {31'd0, gnt1_l2}, 32'd0);
    next_cycle();
    req0 = 1'b0; req1 = 1'b0;
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
